// File: rtl/pll_reset_seq_pkg.sv
// pll_reset_seq_pkg: state codes, opcodes, reset-vector and status-bit positions shared by pll_reset_sequencer
package pll_reset_seq_pkg;
  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_PHI_RST    = 4'd1,
    ST_PHI_WAIT   = 4'd2,
    ST_THETA_RST  = 4'd3,
    ST_THETA_WAIT = 4'd4,
    ST_SETTLE     = 4'd5,
    ST_REL_TDC    = 4'd6,
    ST_REL_AES    = 4'd7,
    ST_DONE       = 4'd8,
    ST_FAULT      = 4'd9
  } state_t;
  localparam logic [1:0] OP_STATUS   = 2'd0;
  localparam logic [1:0] OP_FULL_SEQ = 2'd1;
  localparam logic [1:0] OP_HOLD_ALL = 2'd2;
  localparam logic [1:0] OP_AES_ONLY = 2'd3;
  localparam int RB_AES   = 0;
  localparam int RB_TDC   = 1;
  localparam int RB_THETA = 2;
  localparam int RB_PHI   = 3;
  localparam int SB_ACK   = 0;
  localparam int SB_BUSY  = 1;
  localparam int SB_TMO   = 2;
  localparam int SB_PHI   = 3;
  localparam int SB_THETA = 4;
  localparam int SB_LOST  = 5;
  localparam int SB_STATE = 6;
  localparam int SB_OP    = 10;
  localparam int SYNC_LAG = 2;
endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// sync2: two-flop synchroniser bringing an asynchronous level into the clk domain (o_q lags i_d by 2 cycles)
module sync2 (
  input  logic clk,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;
  always_ff @(posedge clk) begin
    r_meta <= i_d;
    r_q <= r_meta;
  end
  assign o_q = r_q;
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: ordered phi/theta PLL, TDC and AES reset sequencing behind a toggle-handshake cmd_word/status_word PIO pair
module pll_reset_sequencer
  import pll_reset_seq_pkg::*;
#(
  parameter int RESET_HOLD    = 16,
  parameter int LOCK_TIMEOUT  = 1048576,
  parameter int SETTLE_CYCLES = 64,
  parameter int AES_GAP       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cmd_word,
  input  logic        phi_locked,
  input  logic        theta_locked,
  output logic [31:0] status_word,
  output logic        phi_pll_rst,
  output logic        theta_pll_rst,
  output logic        tdc_rst,
  output logic        aes_rst
);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] C_HOLD   = CW'(RESET_HOLD - 1);
  localparam logic [CW-1:0] C_TMO    = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_SETTLE = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] C_GAP    = CW'(AES_GAP - 1);
  localparam logic [CW-1:0] C_LAG    = CW'(SYNC_LAG - 1);
  state_t r_state, w_state_nxt;
  logic [2:0] r_cmd;
  logic [3:0] r_rst, w_rst_nxt;
  logic [1:0] r_last_op, w_last_op_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic r_ack, r_tmo, r_lost;
  logic w_ack_nxt, w_tmo_nxt, w_lost_nxt;
  logic w_phi_s, w_theta_s, w_req, w_loss_act, w_lag, w_tmo_hit, w_unused;
  sync2 u_phi_sync (.clk(clk), .i_d(phi_locked), .o_q(w_phi_s));
  sync2 u_theta_sync (.clk(clk), .i_d(theta_locked), .o_q(w_theta_s));
  assign w_unused = ^cmd_word[31:3];
  assign w_req = (r_cmd[0] != r_ack) && (r_state == ST_IDLE);
  assign w_loss_act = !r_rst[RB_TDC] && !(w_phi_s && w_theta_s) && (r_state inside {ST_IDLE, ST_REL_TDC, ST_REL_AES});
  // a lock seen in the first cycles after a PLL reset release is still the stale pre-reset value in the synchroniser
  assign w_lag = r_cnt >= C_LAG;
  assign w_tmo_hit = r_cnt == C_TMO;
  assign w_cnt_nxt = (w_state_nxt != r_state) ? '0 : r_cnt + CW'(1);
  always_comb begin
    w_state_nxt = r_state;
    w_rst_nxt = r_rst;
    w_ack_nxt = r_ack;
    w_tmo_nxt = r_tmo;
    w_lost_nxt = r_lost;
    w_last_op_nxt = r_last_op;
    // lock loss wins over a pending request; the request is picked up once tdc_rst is back high
    if (w_loss_act) begin
      w_state_nxt = (r_state == ST_IDLE) ? ST_IDLE : ST_DONE;
      w_rst_nxt[RB_TDC] = 1'b1;
      w_rst_nxt[RB_AES] = 1'b1;
      w_lost_nxt = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: if (w_req) begin
          w_last_op_nxt = r_cmd[2:1];
          case (r_cmd[2:1])
            OP_STATUS: w_state_nxt = ST_DONE;
            OP_FULL_SEQ: begin
              w_state_nxt = ST_PHI_RST;
              w_rst_nxt = '1;
              w_tmo_nxt = 1'b0;
              w_lost_nxt = 1'b0;
            end
            OP_HOLD_ALL: begin
              w_state_nxt = ST_DONE;
              w_rst_nxt = '1;
            end
            default: begin
              w_state_nxt = (w_phi_s && w_theta_s && !r_rst[RB_TDC]) ? ST_REL_AES : ST_FAULT;
              w_rst_nxt[RB_AES] = 1'b1;
            end
          endcase
        end
        ST_PHI_RST: if (r_cnt == C_HOLD) begin
          w_state_nxt = ST_PHI_WAIT;
          w_rst_nxt[RB_PHI] = 1'b0;
        end
        ST_PHI_WAIT: if (w_phi_s && w_lag) begin
          w_state_nxt = ST_THETA_RST;
          w_rst_nxt[RB_THETA] = 1'b1;
        end else if (w_tmo_hit) w_state_nxt = ST_FAULT;
        ST_THETA_RST: if (r_cnt == C_HOLD) begin
          w_state_nxt = ST_THETA_WAIT;
          w_rst_nxt[RB_THETA] = 1'b0;
        end
        ST_THETA_WAIT: w_state_nxt = (w_theta_s && w_lag) ? ST_SETTLE : w_tmo_hit ? ST_FAULT : ST_THETA_WAIT;
        ST_SETTLE: begin
          w_state_nxt = !w_phi_s ? ST_PHI_WAIT : !w_theta_s ? ST_THETA_WAIT : (r_cnt == C_SETTLE) ? ST_REL_TDC : ST_SETTLE;
          w_rst_nxt[RB_TDC] = !(w_phi_s && w_theta_s && r_cnt == C_SETTLE);
        end
        ST_REL_TDC: if (r_cnt == C_GAP) begin
          w_state_nxt = ST_REL_AES;
          w_rst_nxt[RB_AES] = 1'b0;
        end
        // full sequence passes straight through; AES_ONLY entered with aes_rst high and holds it RESET_HOLD cycles
        ST_REL_AES: if (r_last_op != OP_AES_ONLY || r_cnt == C_HOLD) begin
          w_state_nxt = ST_DONE;
          w_rst_nxt[RB_AES] = 1'b0;
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
          w_ack_nxt = ~r_ack;
        end
        ST_FAULT: begin
          w_state_nxt = ST_IDLE;
          w_ack_nxt = ~r_ack;
          w_tmo_nxt = 1'b1;
          w_rst_nxt = '1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cmd <= '0;
      r_rst <= '1;
      r_cnt <= '0;
      r_ack <= 1'b0;
      r_tmo <= 1'b0;
      r_lost <= 1'b0;
      r_last_op <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd <= cmd_word[2:0];
      r_rst <= w_rst_nxt;
      r_cnt <= w_cnt_nxt;
      r_ack <= w_ack_nxt;
      r_tmo <= w_tmo_nxt;
      r_lost <= w_lost_nxt;
      r_last_op <= w_last_op_nxt;
    end
  end
  always_comb begin
    status_word = '0;
    status_word[SB_ACK] = r_ack;
    status_word[SB_BUSY] = r_state != ST_IDLE;
    status_word[SB_TMO] = r_tmo;
    status_word[SB_PHI] = w_phi_s;
    status_word[SB_THETA] = w_theta_s;
    status_word[SB_LOST] = r_lost;
    status_word[SB_STATE +: 4] = r_state;
    status_word[SB_OP +: 2] = r_last_op;
  end
  assign phi_pll_rst = r_rst[RB_PHI];
  assign theta_pll_rst = r_rst[RB_THETA];
  assign tdc_rst = r_rst[RB_TDC];
  assign aes_rst = r_rst[RB_AES];
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- FPGA-side responder to the HPS reset/lock control PIOs.
- Takes a 32-bit command word written by the HPS and drives ordered resets to the phi PLL, theta PLL, TDC and AES domains, waiting on PLL lock between steps.
- Returns a 32-bit status word to an HPS input PIO, with a toggle handshake.
- Replaces the per-domain software-driven reset exports with one hardware sequence.

Parameters:
- RESET_HOLD, 16: cycles each PLL reset is held asserted.
- LOCK_TIMEOUT, 1048576: cycles to wait for a lock before faulting.
- SETTLE_CYCLES, 64: cycles after theta lock before the TDC is released.
- AES_GAP, 8: cycles between TDC release and AES release.

Ports:
- clk  in  1  system clock (50 MHz, same domain as the HPS PIOs)
- reset  in  1  synchronous, active-high
- cmd_word  in  32  from HPS PIO; synchronous to clk
  - [0] req toggle
  - [2:1] opcode: 0 STATUS, 1 FULL_SEQ, 2 HOLD_ALL, 3 AES_ONLY
  - [31:3] ignored
- phi_locked  in  1  phi PLL locked; asynchronous
- theta_locked  in  1  theta PLL locked; asynchronous
- status_word  out  32  to HPS PIO
  - [0] ack toggle
  - [1] busy
  - [2] timeout fault (sticky)
  - [3] phi_locked_s
  - [4] theta_locked_s
  - [5] lock_lost (sticky)
  - [9:6] state code
  - [11:10] last opcode
  - [31:12] zero
- phi_pll_rst  out  1  phi PLL reset, active-high
- theta_pll_rst  out  1  theta PLL reset, active-high
- tdc_rst  out  1  TDC reset, active-high
- aes_rst  out  1  AES reset, active-high

Behaviour:
- Reset values:
  - all four domain resets = 1.
  - status_word = 0 except bits [3], [4] (live lock values); state code = IDLE (0).
- Domains stay in reset until a FULL_SEQ completes.
- Lock inputs pass through a 2-FF synchroniser; "_s" denotes the synchronised value, which lags 2 cycles.
- cmd_word is registered once. A request exists when cmd_word_q[0] != ack and state == IDLE.
  - Detection to first state change: 1 cycle.
  - Requests that arrive while busy are not lost: the toggle mismatch persists and is served on return to IDLE. Only the latest opcode is used.
- States (code):
  - IDLE(0)
  - PHI_RST(1): phi_pll_rst, theta_pll_rst, tdc_rst, aes_rst = 1; hold RESET_HOLD cycles.
  - PHI_WAIT(2): phi_pll_rst = 0; wait phi_locked_s.
  - THETA_RST(3): theta_pll_rst = 1 for RESET_HOLD cycles.
  - THETA_WAIT(4): theta_pll_rst = 0; wait theta_locked_s.
  - SETTLE(5): count SETTLE_CYCLES.
  - REL_TDC(6): tdc_rst = 0; count AES_GAP.
  - REL_AES(7): aes_rst = 0.
  - DONE(8): ack <= cmd_word_q[0]; busy = 0; go to IDLE.
  - FAULT(9): set timeout bit; hold all resets = 1; ack; go to IDLE.
- FULL_SEQ:
  - Clears sticky bits, then runs PHI_RST..REL_AES..DONE.
  - Total latency with immediate locks: 1 + 2*RESET_HOLD + 2*(sync 2) + SETTLE_CYCLES + AES_GAP + 2 cycles.
- HOLD_ALL: all resets = 1 in 1 cycle, then DONE.
- AES_ONLY:
  - Requires both locks_s = 1 and tdc_rst = 0; otherwise go to FAULT.
  - aes_rst = 1 for RESET_HOLD cycles, then 0, then DONE.
- STATUS: DONE immediately; only ack toggles.
- busy = 1 in every state except IDLE.
- Timeout:
  - A single counter, width clog2(LOCK_TIMEOUT+1), cleared on entry to each WAIT state.
  - Reaching LOCK_TIMEOUT goes to FAULT.
- Lock loss:
  - In SETTLE, a drop of either lock_s restarts the settle counter and enters the THETA_WAIT or PHI_WAIT state that matches the lost lock.
  - In IDLE/REL_* with tdc_rst = 0, a drop of either lock_s forces tdc_rst = 1 and aes_rst = 1 on the next cycle and sets lock_lost. PLL resets are untouched; recovery requires a new FULL_SEQ.
  - If a lock drop and a request detect occur in the same cycle, the lock-loss action applies first; the request is then served.
- A mid-operation reset returns to the reset values at once, regardless of state.

Decomposition:
- Package pll_reset_seq_pkg:
  - state enum with codes 0-9
  - opcode constants
  - status bit index constants
- One sub-module: sync2, a 2-FF synchroniser instantiated twice.
- Counters and FSM stay in the top module.

Test Plan:
All scenarios use RESET_HOLD=4, LOCK_TIMEOUT=100, SETTLE_CYCLES=8, AES_GAP=2.
- Reset with locks tied 1:
  - all four resets stay 1 and status_word = 0x18 until a command arrives.
  - Write cmd 0x3 (FULL_SEQ, toggle 1) → phi_pll_rst falls 5 cycles later; tdc_rst falls before aes_rst, 2 cycles apart; status[0] = 1 and busy = 0 at the end.
- FULL_SEQ with phi_locked held 0 → FAULT after 100 wait cycles; status[2] = 1; all resets = 1; ack toggles.
- After a successful sequence, drop theta_locked for 1 cycle → tdc_rst = aes_rst = 1 three cycles later; status[5] = 1; PLL resets stay 0.
- Write 0x7 (AES_ONLY) when locked and running → aes_rst high for exactly 4 cycles; tdc_rst stays 0; ack toggles.
- Write 0x3 and then 0x4 (HOLD_ALL, toggle 0) mid-sequence → the FULL_SEQ completes, then HOLD_ALL runs; the final ack = 0 and all resets = 1.
- Assert reset during SETTLE → all resets = 1 and state = 0 on the next cycle.
